// File: rtl/sgmii_rx_rate_adapt.sv
// Receive-side rate adapter: decimates the replicated SGMII symbol stream and
// buffers one copy of each symbol (with K and error flags) for a FWFT reader.
module sgmii_rx_rate_adapt #(
  parameter int LANES        = 2,
  parameter int DEPTH        = 16,
  parameter int PERIOD_100   = 5,
  parameter int PERIOD_10    = 50,
  parameter int SAMPLE_PHASE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               speed,
  input  logic [8*LANES-1:0]       rx_data,
  input  logic [LANES-1:0]         rx_k,
  input  logic [LANES-1:0]         rx_err,
  input  logic                     rd_en,
  input  logic                     clr_flags,
  output logic [7:0]               dout,
  output logic                     dout_k,
  output logic                     dout_err,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int PMAX = (PERIOD_10 > PERIOD_100) ? PERIOD_10 : PERIOD_100;
  localparam int CW   = $clog2(PMAX);

  localparam logic [CW-1:0] P10_M1  = CW'(PERIOD_10 - 1);
  localparam logic [CW-1:0] P100_M1 = CW'(PERIOD_100 - 1);
  localparam logic [CW-1:0] PHASE   = CW'(SAMPLE_PHASE);
  localparam logic [LW-1:0] ROOM_MAX = LW'(DEPTH - LANES);

  logic [8*LANES-1:0] in_data_q;
  logic [LANES-1:0]   in_k_q;
  logic [LANES-1:0]   in_err_q;
  logic [1:0]         speed_q;
  logic [CW-1:0]      cnt_q, cnt_d, p_m1;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [9:0]         mem_q [DEPTH];

  logic speed_chg, strobe, room, wr, pop;

  // Read handshake: dout/dout_k/dout_err show the head entry whenever
  // dout_valid is 1; rd_en pops that entry at the next edge only if
  // dout_valid is 1, otherwise the request is ignored and flagged.
  always_comb begin
    speed_chg = (speed != speed_q);
    p_m1      = '0;
    if (speed_q == 2'b00)      p_m1 = P10_M1;
    else if (speed_q == 2'b01) p_m1 = P100_M1;

    cnt_d = cnt_q + CW'(1);
    if (speed_chg || (cnt_q == p_m1)) cnt_d = '0;

    strobe = speed_q[1] | ((cnt_q == PHASE) & ~speed_chg);
    room   = (level_q <= ROOM_MAX);
    wr     = strobe & room;
    pop    = rd_en & dout_valid;

    wr_ptr_d = wr  ? (wr_ptr_q + PW'(LANES)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PW'(1))     : rd_ptr_q;
    level_d  = level_q + (wr ? LW'(LANES) : LW'(0)) - (pop ? LW'(1) : LW'(0));

    // A fresh event beats a clear issued in the same cycle.
    ovf_d = ovf_q & ~clr_flags;
    unf_d = unf_q & ~clr_flags;
    if (strobe && !room)     ovf_d = 1'b1;
    if (rd_en && !dout_valid) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_data_q <= '0;
      in_k_q    <= '0;
      in_err_q  <= '0;
      speed_q   <= 2'b00;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      in_data_q <= rx_data;
      in_k_q    <= rx_k;
      in_err_q  <= rx_err;
      speed_q   <= speed;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      // DEPTH is a multiple of LANES, so a word never straddles the wrap.
      if (wr) begin
        for (int l = 0; l < LANES; l++)
          mem_q[wr_ptr_q + PW'(l)] <= {in_err_q[l], in_k_q[l], in_data_q[8*l +: 8]};
      end
    end
  end

  assign {dout_err, dout_k, dout} = mem_q[rd_ptr_q];
  assign dout_valid = (level_q != '0);
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_sgmii_rx_rate_adapt.sv
// Directed bench for sgmii_rx_rate_adapt (LANES=2, DEPTH=16, 5/50-cycle periods).
module tb_sgmii_rx_rate_adapt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  speed;
  logic [15:0] rx_data;
  logic [1:0]  rx_k;
  logic [1:0]  rx_err;
  logic        rd_en;
  logic        clr_flags;
  logic [7:0]  dout;
  logic        dout_k;
  logic        dout_err;
  logic        dout_valid;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;
  int tk       = 0;
  logic [7:0] exp_q[$];

  sgmii_rx_rate_adapt #(
    .LANES(2), .DEPTH(16), .PERIOD_100(5), .PERIOD_10(50), .SAMPLE_PHASE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .speed(speed), .rx_data(rx_data), .rx_k(rx_k),
    .rx_err(rx_err), .rd_en(rd_en), .clr_flags(clr_flags), .dout(dout),
    .dout_k(dout_k), .dout_err(dout_err), .dout_valid(dout_valid),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after the next rising edge; tk counts edges since reset.
  task automatic tick();
    @(posedge clk);
    #1;
    tk++;
  endtask

  task automatic tick_to(input int k);
    while (tk < k) tick();
  endtask

  // Pulses reset between edges; inputs set afterwards land before edge E0.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    speed = 2'b00; rx_data = '0; rx_k = '0; rx_err = '0;
    rd_en = 1'b0; clr_flags = 1'b0;
    #4 rst_n = 1'b1;
    tk = 0;
  endtask

  initial begin
    int pops;
    int max_lvl;
    int first_valid;
    logic [7:0] exp_b;

    rst_n = 1'b1; speed = 2'b00; rx_data = '0; rx_k = '0; rx_err = '0;
    rd_en = 1'b0; clr_flags = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dout", {dout_err, dout_k, dout}, 0);
    check("rst_flags", {overflow, underflow}, 0);

    // 1000M latency: two words on consecutive cycles
    do_reset();
    speed = 2'b10; rx_data = 16'h0201; rx_k = 2'b01;
    tick();
    rx_data = 16'h0403; rx_k = 2'b00;
    check("g_valid_e0", dout_valid, 0);
    tick();
    speed = 2'b00;
    check("g_level_e1", level, 2);
    check("g_dout_e1", dout, 8'h01);
    check("g_k_e1", dout_k, 1);
    check("g_valid_e1", dout_valid, 1);
    tick();
    check("g_level_e2", level, 4);
    check("g_ovf_e2", overflow, 0);
    check("g_dout_e2", dout, 8'h01);

    // 100M with continuous reads: one write per 5 cycles, popped 5A/A5
    do_reset();
    speed = 2'b01; rx_data = 16'hA55A; rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hA5);
    end
    pops = 0; max_lvl = 0; first_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (dout_valid && first_valid == 0) first_valid = k;
      if (dout_valid) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("f_pop_extra", dout, 8'hFF);
        end else begin
          exp_b = exp_q.pop_front();
          check("f_pop_data", dout, exp_b);
        end
      end
    end
    rd_en = 1'b0;
    check("f_first_write", first_valid, 4);
    check("f_pop_count", pops, 16);
    check("f_max_level", max_lvl, 2);

    // 10M then switch to 100M mid-stream
    do_reset();
    speed = 2'b00; rx_data = 16'h2211;
    tick_to(2);
    check("s_level_t2", level, 0);
    tick_to(3);
    check("s_level_t3", level, 2);
    tick_to(20);
    speed = 2'b01; rx_data = 16'h4433;
    tick_to(23);
    check("s_level_t23", level, 2);
    tick_to(24);
    check("s_level_t24", level, 4);
    tick_to(28);
    check("s_level_t28", level, 4);
    tick_to(29);
    check("s_level_t29", level, 6);
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    for (int j = 0; j < 4; j++) begin
      exp_b = exp_q.pop_front();
      check("s_seq", dout, exp_b);
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    check("s_level_after", level, 2);
    check("s_head_after", dout, 8'h33);

    // Fill to full and drop the 9th word
    do_reset();
    speed = 2'b10;
    for (int i = 1; i <= 9; i++) begin
      rx_data = {8'(2*i), 8'(2*i-1)};
      tick();
    end
    check("o_level_full", level, 16);
    check("o_ovf_pre", overflow, 0);
    speed = 2'b00;
    tick();
    check("o_level_drop", level, 16);
    check("o_ovf_set", overflow, 1);
    check("o_head", dout, 8'h01);
    check("o_valid", dout_valid, 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("o_ovf_clr", overflow, 0);
    check("o_level_hold", level, 16);

    // Underflow, clear/set race, pop-from-empty with concurrent write
    do_reset();
    speed = 2'b00; rd_en = 1'b1;
    tick();
    check("u_set", underflow, 1);
    check("u_level", level, 0);
    check("u_valid", dout_valid, 0);
    clr_flags = 1'b1;
    tick();
    check("u_race", underflow, 1);
    clr_flags = 1'b0;
    tick();
    check("u_wr_pop_level", level, 2);
    check("u_wr_pop_flag", underflow, 1);
    rd_en = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("u_clr", underflow, 0);
    check("u_level_keep", level, 2);

    // Level 14, write and pop together, then asynchronous reset
    do_reset();
    speed = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      rx_data = {8'(2*i), 8'(2*i-1)};
      tick();
    end
    check("w_level14", level, 14);
    rd_en = 1'b1; speed = 2'b00;
    tick();
    rd_en = 1'b0;
    check("w_level15", level, 15);
    check("w_ovf", overflow, 0);
    check("w_head", dout, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("a_level", level, 0);
    check("a_valid", dout_valid, 0);
    check("a_dout", {dout_err, dout_k, dout}, 0);
    check("a_flags", {overflow, underflow}, 0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
